// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 8 data bits, LSB first, with 1 start bit and 1 stop bit.
// Ports: clk, rst (sync, active-high), rx_signal (async serial in, idles high),
//        rx_byte (last good byte), rx_dv (1-cycle valid pulse),
//        rx_err (1-cycle framing/parity error pulse), rx_busy (FSM not idle).
// Optional: define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx #(
  parameter logic [7:0] clk_per_bit = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_signal,
  output logic [7:0] rx_byte,
  output logic       rx_dv,
  output logic       rx_err,
  output logic       rx_busy
);
  localparam logic [7:0] half = (clk_per_bit - 8'd1) >> 1;
  localparam logic [7:0] last = clk_per_bit - 8'd1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {idle, start, data, parity, stop, clean} state_t;
  logic perr;
`else
  typedef enum logic [2:0] {idle, start, data, stop, clean} state_t;
`endif
  state_t      state;
  logic [7:0]  count;
  logic [7:0]  shift;
  logic [3:0]  index;
  logic        s1;
  logic        rx_s;
  logic        rx_p;
  logic [1:0]  flush;
  logic        armed;
  logic        stop_ok;
`ifdef UART_RX_PARITY_EN
  assign stop_ok = rx_s & ~perr;
`else
  assign stop_ok = rx_s;
`endif
  // Start edges are ignored until the synchroniser has flushed its reset
  // value and the line has really been seen high, so a low line at reset
  // release is not taken as a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= idle;
      count   <= 8'd0;
      index   <= 4'd0;
      shift   <= 8'd0;
      rx_byte <= 8'h00;
      rx_dv   <= 1'b0;
      rx_err  <= 1'b0;
      rx_busy <= 1'b0;
      s1      <= 1'b1;
      rx_s    <= 1'b1;
      rx_p    <= 1'b1;
      flush   <= 2'd0;
      armed   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr    <= 1'b0;
`endif
    end else begin
      {rx_p, rx_s, s1} <= {rx_s, s1, rx_signal};
      flush   <= flush + {1'b0, ~&flush};
      armed   <= armed | (&flush & rx_s & rx_p);
      rx_dv   <= 1'b0;
      rx_err  <= 1'b0;
      rx_busy <= state != idle;
      case (state)
        idle: begin
          count <= 8'd0;
          index <= 4'd0;
          if (armed && rx_p && !rx_s) state <= start;
        end
        start: begin
          count <= count == half ? 8'd0 : count + 8'd1;
          if (count == half) state <= rx_s ? idle : data;
        end
        data: begin
          count <= count == last ? 8'd0 : count + 8'd1;
          if (count == last) begin
            shift[index[2:0]] <= rx_s;
            index <= index + 4'd1;
`ifdef UART_RX_PARITY_EN
            if (index == 4'd7) state <= parity;
`else
            if (index == 4'd7) state <= stop;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        parity: begin
          count <= count == last ? 8'd0 : count + 8'd1;
          if (count == last) begin
            perr  <= ^shift ^ rx_s;
            state <= stop;
          end
        end
`endif
        stop: begin
          count <= count == last ? 8'd0 : count + 8'd1;
          if (count == last) begin
            rx_dv   <= stop_ok;
            rx_err  <= ~stop_ok;
            rx_byte <= stop_ok ? shift : rx_byte;
            state   <= clean;
          end
        end
        clean: state <= rx_s ? idle : clean;
        default: state <= idle;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level scoreboard.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) >> 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT = 3 + HALF + 9 * CPB + (PAR ? CPB : 0);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_signal = 1'b1;
  logic [7:0] rx_byte;
  logic rx_dv;
  logic rx_err;
  logic rx_busy;
  uart_rx #(.clk_per_bit(8'(CPB))) dut (
    .clk(clk), .rst(rst), .rx_signal(rx_signal),
    .rx_byte(rx_byte), .rx_dv(rx_dv), .rx_err(rx_err), .rx_busy(rx_busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int errors = 0;
  int checks = 0;
  logic [7:0] dv_q[$];
  int dv_t[$];
  int err_seen = 0;
  int bad_pulse = 0;
  logic pdv = 1'b0;
  logic perr_d = 1'b0;
  logic [7:0] exp_q[$];
  int exp_err = 0;
  logic [7:0] last_good = 8'h00;
  int t_start;
  int t_a5;
  int lat;
  logic busy_mid;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_dv) begin
        dv_q.push_back(rx_byte);
        dv_t.push_back(cyc);
      end
      if (rx_err) err_seen++;
      if ((rx_dv && rx_err) || (rx_dv && pdv) || (rx_err && perr_d)) bad_pulse++;
    end
    pdv = rx_dv;
    perr_d = rx_err;
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic v);
    rx_signal = v;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic idle(input int n);
    rx_signal = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic sb, input logic pb);
    bit ok;
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      if (i == 4) busy_mid = rx_busy;
    end
    if (PAR) drive_bit(pb);
    drive_bit(sb);
    ok = sb && (!PAR || (pb == ^b));
    if (ok) begin
      exp_q.push_back(b);
      last_good = b;
    end else exp_err++;
  endtask
  task automatic score(input string tag);
    check({tag, "_dv_count"}, dv_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < dv_q.size()) check({tag, "_byte"}, dv_q[i], exp_q[i]);
    check({tag, "_err_count"}, err_seen, exp_err);
    check({tag, "_pulse_shape"}, bad_pulse, 0);
    dv_q.delete();
    dv_t.delete();
    exp_q.delete();
    err_seen = 0;
    exp_err = 0;
    bad_pulse = 0;
  endtask
  initial begin
    logic [7:0] b;
    logic sb;
    logic pb;
    repeat (4) @(negedge clk);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_rx_dv", rx_dv, 0);
    check("reset_rx_err", rx_err, 0);
    check("reset_rx_busy", rx_busy, 0);
    rst = 1'b0;
    idle(10);
    check("idle_busy", rx_busy, 0);
    t_a5 = cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    t_a5 = t_start;
    check("a5_busy_mid", busy_mid, 1);
    idle(2 * CPB);
    if (dv_t.size() > 0) begin
      lat = dv_t[0] - t_a5 - 1;
      check("a5_latency_window", int'(lat >= LAT && lat <= LAT + 2), 1);
    end
    check("a5_rx_byte", rx_byte, 8'hA5);
    check("a5_busy_after", rx_busy, 0);
    score("a5");
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(2 * CPB);
    score("b2b");
    rx_signal = 1'b0;
    repeat (3) @(negedge clk);
    idle(2 * CPB);
    check("glitch_busy", rx_busy, 0);
    score("glitch");
    send_frame(8'h55, 1'b0, ^8'h55);
    rx_signal = 1'b0;
    repeat (40) @(negedge clk);
    check("clean_wait_busy", rx_busy, 1);
    check("err_rx_byte_held", rx_byte, last_good);
    idle(CPB);
    check("clean_exit_busy", rx_busy, 0);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(2 * CPB);
    score("framing");
    rx_signal = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (10) @(negedge clk);
    check("low_reset_busy", rx_busy, 0);
    idle(20);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(2 * CPB);
    score("low_reset");
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    rx_signal = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    idle(2 * CPB);
    check("midrst_rx_byte", rx_byte, 8'h00);
    check("midrst_busy", rx_busy, 0);
    score("midrst");
    b = 8'($urandom);
    send_frame(b, 1'b1, ^b);
    idle(2 * CPB);
    score("after_midrst");
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(CPB);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    check("parity_rx_byte", rx_byte, 8'h07);
    score("parity");
`endif
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      sb = $urandom_range(0, 3) != 0;
      pb = ($urandom_range(0, 3) != 0) ? ^b : ~^b;
      send_frame(b, sb, pb);
      idle(sb ? int'($urandom_range(0, 4)) : 2 * CPB);
    end
    idle(2 * CPB);
    check("random_rx_byte", rx_byte, last_good);
    score("random");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Pairs with the team's uart_tx on the same serial link, using the same clk_per_bit bit timing.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); idle line is 1.
- Synchronises the asynchronous serial input, finds the start edge, samples each bit at mid-bit and presents a received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the byte-consuming logic.

Parameters:
- clk_per_bit, 8'd100, clock cycles per bit = f_clk / baud. Legal range 4..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_signal  in  1  asynchronous serial line; idle 1.
- rx_byte  out  8  last good received byte; updates only when rx_dv asserts, holds otherwise.
- rx_dv  out  1  one-cycle pulse: new valid byte on rx_byte.
- rx_err  out  1  one-cycle pulse: frame rejected (framing error; parity error when enabled).
- rx_busy  out  1  high whenever the FSM is not in idle.

Behaviour:
- Reset: state=idle; count=0; index=0; shift register=0; rx_byte=8'h00; rx_dv=0; rx_err=0; rx_busy=0; both synchroniser flops=1; prev-sample flop=1.
- Synchroniser: rx_signal passes through 2 flops to give rx_s, then 1 more flop to give rx_p. The FSM only ever uses rx_s and rx_p.
- count is 8 bits; index is 4 bits.
- Mid-bit point: half = (clk_per_bit-1)>>1.
- idle:
  - count=0, index=0.
  - Go to start only on a falling edge (rx_p==1 and rx_s==0).
  - A line that is already low after reset, or stuck low, is not accepted as a start bit.
- start:
  - Increment count until count==half.
  - At that point: if rx_s==0, count=0 and go to data.
  - Otherwise it is a glitch: go to idle with no rx_dv and no rx_err.
- data:
  - Increment count until count==clk_per_bit-1.
  - At that point: shift[index]<=rx_s, count=0, index=index+1.
  - After the sample at index 7, go to stop (or parity when the optional feature is enabled).
- stop:
  - Count to clk_per_bit-1, then sample rx_s.
  - rx_s==1: rx_byte<=shift and rx_dv=1 for exactly one cycle.
  - rx_s==0: rx_err=1 for exactly one cycle; rx_byte unchanged.
  - Either way, go to clean.
- clean:
  - rx_dv and rx_err return to 0.
  - Go to idle once rx_s==1. If the line is low (break or framing error), wait in clean.
- rx_dv and rx_err are never high in the same cycle and never stay high for more than 1 cycle.
- rx_busy is registered, decoded from state != idle.
- Latency: with a falling edge at the pin in cycle T, rx_dv asserts in cycle T + 3 + half + 9*clk_per_bit + k, where 0<=k<=2 (pipeline slack, fixed per implementation).
- A back-to-back frame whose start edge arrives right after the stop bit is received without loss; clean lasts only 1 cycle when the line is high.
- rst asserted mid-frame: the partial frame is abandoned, with no rx_dv and no rx_err. Reception resumes on the next genuine falling edge.
- An unused default state goes to idle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 11 bits: 1 start, 8 data, 1 even-parity bit, 1 stop.
  - An extra state parity follows data. It counts clk_per_bit-1 cycles, samples rx_s and latches perr = ^shift ^ rx_s.
  - In stop, rx_dv requires stop==1 and perr==0. Otherwise rx_err pulses and rx_byte is unchanged.
  - Latency grows by clk_per_bit.
- Undefined: no parity state, no perr flop; 10-bit frame exactly as described above.

Test Plan:
- clk_per_bit=16. After reset, drive the frame for 8'hA5 (start, bits 1,0,1,0,0,1,0,1, stop) → exactly one rx_dv pulse, rx_byte=8'hA5, rx_err never high, rx_busy high for the frame.
- Three back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap → three rx_dv pulses in order with the matching rx_byte values.
- 3-cycle low glitch on an idle line → FSM returns to idle, with no rx_dv and no rx_err.
- Frame 8'h55 with the stop bit driven 0, then the line held low 40 cycles, then frame 8'h12 → one rx_err pulse; rx_byte stays at its old value; FSM waits in clean until the line is high; then rx_dv with 8'h12.
- Line held low through reset release, then high 20 cycles, then frame 8'h81 → no spurious frame; one rx_dv with 8'h81.
- UART_RX_PARITY_EN: 8'h07 with parity bit 1 → rx_dv; 8'h07 with parity bit 0 → rx_err; rst mid-frame → no pulse.
